// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - single-outstanding instruction fetch stage with PC redirect.
// Optional IFETCH_TIMEOUT_EN adds a stalled-fetch watchdog with a sticky fetch_err and ERR state.
module instr_fetch_unit #(
  parameter logic [15:0] RESET_PC       = 16'h0000,
  parameter int          TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_ack,
  input  logic [15:0] imem_rdata,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] instr_out,
  output logic [15:0] out_pc,
  output logic [15:0] out_pc_plus2,
  input  logic        redirect_valid,
  input  logic [15:0] redirect_pc,
  output logic        fetch_err
);

`ifdef IFETCH_TIMEOUT_EN
  typedef enum logic [2:0] {IDLE, FETCH, DRAIN, HOLD, ERR} state_e;
`else
  typedef enum logic [2:0] {IDLE, FETCH, DRAIN, HOLD} state_e;
`endif

  state_e      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] instr_q, instr_d;
  logic [15:0] out_pc_q, out_pc_d;
  logic [15:0] redir_pc;
  logic        timeout;

  assign redir_pc = redirect_pc & 16'hFFFE;

`ifdef IFETCH_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             stall;

  // Counts consecutive cycles an issued request waits for its ack.
  assign stall   = (state_q == FETCH || state_q == DRAIN) && !imem_ack;
  assign cnt_d   = stall ? cnt_q + CNT_W'(1) : '0;
  assign timeout = stall && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign fetch_err = (state_q == ERR);
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
  assign timeout   = 1'b0;
  assign fetch_err = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    addr_d   = addr_q;
    instr_d  = instr_q;
    out_pc_d = out_pc_q;
    case (state_q)
      IDLE: begin
        state_d = FETCH;
        if (redirect_valid) pc_d = redir_pc;
      end
      FETCH: begin
        addr_d = pc_q;
        if (timeout) begin
`ifdef IFETCH_TIMEOUT_EN
          state_d = ERR;
`endif
        end else if (redirect_valid) begin
          // Without an ack the request is still in flight and must drain first.
          pc_d    = redir_pc;
          state_d = imem_ack ? FETCH : DRAIN;
        end else if (imem_ack) begin
          instr_d  = imem_rdata;
          out_pc_d = pc_q;
          pc_d     = pc_q + 16'd2;
          state_d  = HOLD;
        end
      end
      DRAIN: begin
        if (timeout) begin
`ifdef IFETCH_TIMEOUT_EN
          state_d = ERR;
`endif
        end else begin
          if (redirect_valid) pc_d = redir_pc;
          if (imem_ack)       state_d = FETCH;
        end
      end
      HOLD: begin
        if (redirect_valid) begin
          pc_d    = redir_pc;
          state_d = FETCH;
        end else if (out_ready) begin
          state_d = FETCH;
        end
      end
`ifdef IFETCH_TIMEOUT_EN
      ERR: state_d = ERR;
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      pc_q     <= RESET_PC;
      addr_q   <= RESET_PC;
      instr_q  <= 16'h0000;
      out_pc_q <= 16'h0000;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      addr_q   <= addr_d;
      instr_q  <= instr_d;
      out_pc_q <= out_pc_d;
    end
  end

  assign imem_req     = (state_q == FETCH) || (state_q == DRAIN);
  assign imem_addr    = (state_q == DRAIN) ? addr_q : pc_q;
  assign out_valid    = (state_q == HOLD);
  assign instr_out    = instr_q;
  assign out_pc       = out_pc_q;
  assign out_pc_plus2 = out_pc_q + 16'd2;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb/tb_instr_fetch_unit.sv - directed and randomized check of instr_fetch_unit against a transaction model.
module tb_instr_fetch_unit;
  localparam int T = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [15:0] imem_rdata = 16'h0000;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] instr_out;
  logic [15:0] out_pc;
  logic [15:0] out_pc_plus2;
  logic        redirect_valid = 1'b0;
  logic [15:0] redirect_pc = 16'h0000;
  logic        fetch_err;

  int n_cmp = 0;
  int n_bad = 0;

  instr_fetch_unit #(.RESET_PC(16'h0000), .TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .out_valid(out_valid), .out_ready(out_ready),
    .instr_out(instr_out), .out_pc(out_pc), .out_pc_plus2(out_pc_plus2),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .fetch_err(fetch_err)
  );

  always #5 clk = ~clk;

  // Transaction-level model: one outstanding request, one held instruction.
  logic        m_busy, m_stale, m_have, m_err;
  logic [15:0] m_pc, m_addr, m_instr, m_ipc;
  int          m_stall;

  task automatic model_step();
    logic [15:0] npc;
    if (reset) begin
      m_pc = 16'h0000; m_addr = 16'h0000; m_busy = 0; m_stale = 0;
      m_have = 0; m_err = 0; m_stall = 0; m_instr = 0; m_ipc = 0;
      return;
    end
    if (m_err) return;
`ifdef IFETCH_TIMEOUT_EN
    if (m_busy && !imem_ack) begin
      m_stall++;
      if (m_stall == T) begin
        m_err = 1; m_busy = 0; m_have = 0;
        return;
      end
    end else begin
      m_stall = 0;
    end
`endif
    npc = redirect_valid ? (redirect_pc & 16'hFFFE) : m_pc;
    if (m_have && (redirect_valid || out_ready)) m_have = 0;
    if (m_busy && imem_ack) begin
      m_busy = 0;
      if (!m_stale && !redirect_valid) begin
        m_have = 1; m_instr = imem_rdata; m_ipc = m_addr; npc = m_addr + 16'd2;
      end
      m_stale = 0;
    end else if (m_busy && redirect_valid) begin
      m_stale = 1;
    end
    m_pc = npc;
    if (!m_busy && !m_have && !m_err) begin
      m_busy = 1; m_addr = m_pc;
    end
  endtask

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("req", 16'(imem_req), 16'(m_busy && !m_err));
    chk("valid", 16'(out_valid), 16'(m_have));
    chk("err", 16'(fetch_err), 16'(m_err));
    if (m_busy && !m_err) chk("addr", imem_addr, m_addr);
    if (m_have) begin
      chk("instr", instr_out, m_instr);
      chk("pc", out_pc, m_ipc);
      chk("pc_plus2", out_pc_plus2, m_ipc + 16'd2);
    end
  end

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  initial begin
    tick();
    chk("rst_req", 16'(imem_req), 16'h0);
    chk("rst_addr", imem_addr, 16'h0000);
    chk("rst_valid", 16'(out_valid), 16'h0);
    chk("rst_instr", instr_out, 16'h0000);
    chk("rst_pc", out_pc, 16'h0000);
    chk("rst_pc_plus2", out_pc_plus2, 16'h0002);
    chk("rst_err", 16'(fetch_err), 16'h0);
    reset = 0;
    tick();
    chk("first_req", 16'(imem_req), 16'h1);
    chk("first_addr", imem_addr, 16'h0000);
    imem_ack = 1; imem_rdata = 16'h2123;
    tick();
    chk("first_valid", 16'(out_valid), 16'h1);
    chk("first_instr", instr_out, 16'h2123);
    chk("first_pc", out_pc, 16'h0000);
    chk("first_pc2", out_pc_plus2, 16'h0002);
    imem_ack = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("hold_instr", instr_out, 16'h2123);
      chk("hold_req", 16'(imem_req), 16'h0);
    end
    out_ready = 1;
    tick();
    chk("accept_req", 16'(imem_req), 16'h1);
    chk("accept_addr", imem_addr, 16'h0002);
    out_ready = 0; imem_ack = 1; imem_rdata = 16'h1111;
    tick();
    chk("second_instr", instr_out, 16'h1111);
    imem_ack = 0; redirect_valid = 1; redirect_pc = 16'h0041; out_ready = 1;
    tick();
    chk("hold_redir_valid", 16'(out_valid), 16'h0);
    chk("hold_redir_addr", imem_addr, 16'h0040);
    out_ready = 0; redirect_pc = 16'h0010; imem_ack = 1; imem_rdata = 16'h5555;
    tick();
    chk("fetch_ack_redir_addr", imem_addr, 16'h0010);
    redirect_pc = 16'h0080; imem_ack = 0;
    tick();
    chk("drain_addr0", imem_addr, 16'h0010);
    redirect_valid = 0;
    tick();
    chk("drain_addr1", imem_addr, 16'h0010);
    imem_ack = 1; imem_rdata = 16'hBEEF;
    tick();
    chk("drain_done_valid", 16'(out_valid), 16'h0);
    chk("drain_done_addr", imem_addr, 16'h0080);
    redirect_valid = 1; redirect_pc = 16'hFFFE; imem_rdata = 16'h0000;
    tick();
    chk("wrap_addr", imem_addr, 16'hFFFE);
    redirect_valid = 0; imem_rdata = 16'hD005;
    tick();
    chk("wrap_instr", instr_out, 16'hD005);
    chk("wrap_pc", out_pc, 16'hFFFE);
    chk("wrap_pc2", out_pc_plus2, 16'h0000);
    imem_ack = 0; out_ready = 1;
    tick();
    chk("wrap_next_addr", imem_addr, 16'h0000);
    out_ready = 0;
    for (int i = 0; i < 12; i++) tick();
`ifdef IFETCH_TIMEOUT_EN
    chk("timeout_err", 16'(fetch_err), 16'h1);
    chk("timeout_req", 16'(imem_req), 16'h0);
`else
    chk("stall_req", 16'(imem_req), 16'h1);
    chk("stall_err", 16'(fetch_err), 16'h0);
`endif
    reset = 1;
    tick();
    reset = 0;
    for (int i = 0; i < 4000; i++) begin
      reset          = ($urandom_range(299) == 0);
      imem_ack       = ($urandom_range(1) == 0);
      imem_rdata     = 16'($urandom);
      out_ready      = ($urandom_range(1) == 0);
      redirect_valid = ($urandom_range(11) == 0);
      redirect_pc    = 16'($urandom);
      tick();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
Fetch stage directly upstream of the opcode decoder/control unit in the 16-bit RISC core. Holds the PC and issues one request at a time to instruction memory over a req/ack handshake. Presents the fetched 16-bit instruction (opcode = instr_out[15:12]) with its PC to decode over a valid/ready handshake. Accepts PC redirects from branch/jump resolution and discards any fetch that is in flight when a redirect arrives.

Parameters:
RESET_PC, 16'h0000, PC value loaded on reset; bit 0 must be 0.
TIMEOUT_CYCLES, 255, cycles without imem_ack before a fetch error is raised (IFETCH_TIMEOUT_EN builds only); minimum 1.

Ports:
clk  input  1  single clock, all logic on rising edge
reset  input  1  synchronous, active-high
imem_req  output  1  fetch request to instruction memory
imem_addr  output  16  byte address of the fetch; bit 0 always 0
imem_ack  input  1  memory returns imem_rdata this cycle; ignored when imem_req=0
imem_rdata  input  16  instruction word, sampled only when imem_req&imem_ack
out_valid  output  1  instr_out/out_pc hold a valid instruction
out_ready  input  1  decode accepts this cycle
instr_out  output  16  fetched instruction to decode/control unit
out_pc  output  16  address of instr_out
out_pc_plus2  output  16  out_pc+2, for branch/jump target calculation
redirect_valid  input  1  change PC (taken BEQ/BNE or J)
redirect_pc  input  16  new PC; bit 0 ignored, treated as 0
fetch_err  output  1  sticky fetch timeout flag; constant 0 when IFETCH_TIMEOUT_EN is undefined

Behaviour:
- Reset (sync, active-high) dominates all inputs: pc=RESET_PC, state=IDLE, imem_req=0, imem_addr=RESET_PC, out_valid=0, instr_out=16'h0000, out_pc=16'h0000, out_pc_plus2=16'h0002, fetch_err=0, timeout counter=0.
- Downstream gates reg_write/mem_write/branch with out_valid; instr_out is don't-care while out_valid=0.
- States: IDLE, FETCH, DRAIN, HOLD, ERR (ERR exists only with IFETCH_TIMEOUT_EN).
- IDLE: unconditionally goes to FETCH next cycle.
- FETCH: imem_req=1, imem_addr=pc. Both are held stable until ack.
  - ack with no redirect: next cycle instr_out=imem_rdata, out_pc=pc, out_pc_plus2=pc+2, out_valid=1, pc=pc+2, state=HOLD.
  - Best-case latency is 1 cycle from ack to out_valid.
- HOLD: out_valid=1, imem_req=0. All outputs are held while out_ready=0.
  - out_valid&out_ready with no redirect: next cycle out_valid=0, state=FETCH.
  - Throughput is at most one instruction per 2 cycles.
- Redirect has priority over accept and ack. In any state except ERR, redirect_valid sets pc={redirect_pc[15:1],1'b0} and out_valid=0 on the next cycle.
  - HOLD: held instruction dropped (even if out_ready=1); state=FETCH.
  - FETCH, ack in the same cycle: rdata discarded; state=FETCH at the new pc.
  - FETCH, no ack: the outstanding request must complete, so state=DRAIN.
  - DRAIN, redirect again: pc updated, stays in DRAIN.
- DRAIN: imem_req=1, imem_addr = the original outstanding address (the request is never changed mid-flight). On ack: rdata discarded, state=FETCH using the latest pc. out_valid stays 0.
- PC arithmetic is 16-bit modulo: 16'hFFFE+2 = 16'h0000, out_pc_plus2 wraps the same way. No fault is raised on wrap.
- Reset mid-fetch: the request is abandoned immediately (imem_req=0 next cycle). Memory must tolerate a dropped request.

Optional Feature:
IFETCH_TIMEOUT_EN
- Defined: a counter increments each cycle with imem_req=1 & imem_ack=0 and clears on ack or on leaving FETCH/DRAIN.
  - When it reaches TIMEOUT_CYCLES: next cycle fetch_err=1, imem_req=0, out_valid=0, state=ERR.
  - ERR ignores all inputs until reset.
- Undefined: no counter and no ERR state; FETCH/DRAIN wait indefinitely; fetch_err is tied to 0.

Test Plan:
- Reset, ack 1 cycle after req with rdata=16'h2123 -> imem_addr=16'h0000; out_valid=1, instr_out=16'h2123, out_pc=16'h0000, out_pc_plus2=16'h0002; after accept, next imem_addr=16'h0002.
- out_ready=0 for 3 cycles in HOLD -> instr_out/out_pc stable, imem_req=0 throughout; accept on cycle 4 -> imem_req=1 next cycle.
- Redirect to 16'h0041 in HOLD with out_ready=1 -> out_valid=0 next cycle, next imem_addr=16'h0040, old instruction never accepted.
- Redirect to 16'h0080 while a fetch of 16'h0010 is outstanding, ack 2 cycles later with 16'hBEEF -> imem_addr stays 16'h0010 until ack; 16'hBEEF is never presented; next imem_addr=16'h0080.
- Redirect to 16'hFFFE, ack 16'hD005, accept -> out_pc=16'hFFFE, out_pc_plus2=16'h0000, next imem_addr=16'h0000.
- IFETCH_TIMEOUT_EN with TIMEOUT_CYCLES=8, imem_ack held 0 -> fetch_err=1 and imem_req=0 after 8 stalled cycles; both remain until reset. Macro undefined -> imem_req stays 1 and fetch_err stays 0.
